pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Sits beside the register/CSR forwarding network and sequences it.
- Detects load-use hazards, which forwarding cannot cover, and issues stall/bubble.
- Holds the pipe for the multi-cycle divider and drives jump redirect plus multi-cycle IF/ID flush.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/haz_load_use_det.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, FSM state encodings and a saturating increment helper
// for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int CPU_WIDTH      = 32;

  typedef enum logic [1:0] {
    HAZ_IDLE       = 2'd0,
    HAZ_DIV_BUSY   = 2'd1,
    HAZ_JUMP_FLUSH = 2'd2
  } haz_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CPU_WIDTH-1:0] sat_inc(input logic [CPU_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/haz_load_use_det.sv
// Purely combinational load-use hazard compare between the ID source
// registers and the destination of a load sitting in EX. x0 never hazards.
module haz_load_use_det
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                      rd1_en,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic                      rd2_en,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic                      ex_load,
  input  logic                      ex_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      hazard
);

  // A load result is not forwardable in time, so any matching read stalls.
  always_comb begin
    hazard = ex_load & ex_wr_en & (ex_rd != '0) &
             ((rd1_en & (rs1 == ex_rd)) | (rd2_en & (rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, jump redirect with a
// multi-cycle IF/ID flush, and divider hold with a watchdog.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
//
// state          | meaning
// HAZ_IDLE       | normal flow; load-use, jump and divide start detected here
// HAZ_JUMP_FLUSH | extra IF/ID flush cycles after a jump
// HAZ_DIV_BUSY   | pipe held while the divider runs, watchdog counting
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int JUMP_FLUSH_CYC = 2,
  parameter int DIV_TIMEOUT    = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_reg1_rd_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg1_rd_adder_i,
  input  logic                      id_reg2_rd_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg2_rd_adder_i,
  input  logic                      ex_load_i,
  input  logic                      ex_reg_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_adder_i,
  input  logic                      ex_jump_i,
  input  logic [CPU_WIDTH-1:0]      ex_jump_adder_i,
  input  logic                      div_start_i,
  input  logic                      div_done_i,
  output logic                      hold_pc_o,
  output logic                      hold_if_id_o,
  output logic                      hold_id_ex_o,
  output logic                      flush_if_id_o,
  output logic                      flush_id_ex_o,
  output logic                      jump_en_o,
  output logic [CPU_WIDTH-1:0]      jump_adder_o,
  output logic                      div_timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CPU_WIDTH-1:0]      stall_cnt_o,
  output logic [CPU_WIDTH-1:0]      flush_cnt_o
`endif
);

  localparam int JCNT_W = $clog2(JUMP_FLUSH_CYC) + 1;
  localparam int DCNT_W = $clog2(DIV_TIMEOUT) + 1;
  localparam logic [JCNT_W-1:0] JCNT_LAST = JCNT_W'(JUMP_FLUSH_CYC - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIV_TIMEOUT - 1);

  haz_state_t        state_q, state_d;
  logic [JCNT_W-1:0] jcnt_q, jcnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              load_use;

  haz_load_use_det u_det (
    .rd1_en   (id_reg1_rd_en_i),
    .rs1      (id_reg1_rd_adder_i),
    .rd2_en   (id_reg2_rd_en_i),
    .rs2      (id_reg2_rd_adder_i),
    .ex_load  (ex_load_i),
    .ex_wr_en (ex_reg_wr_en_i),
    .ex_rd    (ex_reg_wr_adder_i),
    .hazard   (load_use)
  );

  // State and counter registers; reset aborts any divide or flush in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HAZ_IDLE;
      jcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      jcnt_q  <= jcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next state and combinational pipe controls; everything forced low in reset.
  always_comb begin
    state_d       = state_q;
    jcnt_d        = jcnt_q;
    dcnt_d        = dcnt_q;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    jump_en_o     = 1'b0;
    jump_adder_o  = '0;
    div_timeout_o = 1'b0;

    case (state_q)
      HAZ_IDLE: begin
        if (ex_jump_i) begin
          // Jump wins; a divide issued alongside it is on the wrong path.
          jump_en_o     = 1'b1;
          jump_adder_o  = ex_jump_adder_i;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          if (JUMP_FLUSH_CYC > 1) begin
            state_d = HAZ_JUMP_FLUSH;
            jcnt_d  = JCNT_W'(1);
          end
        end else begin
          if (load_use) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
          end
          if (div_start_i) begin
            state_d = HAZ_DIV_BUSY;
            dcnt_d  = '0;
          end
        end
      end

      HAZ_JUMP_FLUSH: begin
        flush_if_id_o = 1'b1;
        if (jcnt_q == JCNT_LAST) begin
          state_d = HAZ_IDLE;
          jcnt_d  = '0;
        end else begin
          jcnt_d = jcnt_q + 1'b1;
        end
      end

      HAZ_DIV_BUSY: begin
        if (div_done_i) begin
          state_d = HAZ_IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          // Final watchdog cycle: release the pipe and flag the hang.
          div_timeout_o = 1'b1;
          state_d       = HAZ_IDLE;
          dcnt_d        = '0;
        end else begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          dcnt_d       = dcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = HAZ_IDLE;
        jcnt_d  = '0;
        dcnt_d  = '0;
      end
    endcase

    if (!rst_n) begin
      hold_pc_o     = 1'b0;
      hold_if_id_o  = 1'b0;
      hold_id_ex_o  = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      jump_en_o     = 1'b0;
      jump_adder_o  = '0;
      div_timeout_o = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of stalled and IF/ID-flushed cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hold_pc_o)     stall_cnt_o <= sat_inc(stall_cnt_o);
      if (flush_if_id_o) flush_cnt_o <= sat_inc(flush_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cases from the test plan
// followed by randomized traffic, checked against a behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int JFC = 2;
  localparam int DTO = 40;

  logic clk = 1'b0;
  logic rst_n;
  logic rd1_en, rd2_en, ex_load, ex_wr_en, ex_jump, div_start, div_done;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, ex_rd;
  logic [CPU_WIDTH-1:0] jump_tgt;

  logic hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_en, div_timeout;
  logic [CPU_WIDTH-1:0] jump_adder;
  logic [CPU_WIDTH-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.JUMP_FLUSH_CYC(JFC), .DIV_TIMEOUT(DTO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_reg1_rd_en_i    (rd1_en),
    .id_reg1_rd_adder_i (rs1),
    .id_reg2_rd_en_i    (rd2_en),
    .id_reg2_rd_adder_i (rs2),
    .ex_load_i          (ex_load),
    .ex_reg_wr_en_i     (ex_wr_en),
    .ex_reg_wr_adder_i  (ex_rd),
    .ex_jump_i          (ex_jump),
    .ex_jump_adder_i    (jump_tgt),
    .div_start_i        (div_start),
    .div_done_i         (div_done),
    .hold_pc_o          (hold_pc),
    .hold_if_id_o       (hold_if_id),
    .hold_id_ex_o       (hold_id_ex),
    .flush_if_id_o      (flush_if_id),
    .flush_id_ex_o      (flush_id_ex),
    .jump_en_o          (jump_en),
    .jump_adder_o       (jump_adder),
    .div_timeout_o      (div_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o        (stall_cnt),
    .flush_cnt_o        (flush_cnt)
`endif
  );

`ifndef HAZARD_PERF_CNT_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  typedef struct packed {
    logic                 hold_pc;
    logic                 hold_if_id;
    logic                 hold_id_ex;
    logic                 flush_if_id;
    logic                 flush_id_ex;
    logic                 jump_en;
    logic [CPU_WIDTH-1:0] jump_adder;
    logic                 div_timeout;
    logic [CPU_WIDTH-1:0] stall_cnt;
    logic [CPU_WIDTH-1:0] flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: remaining flush cycles, divider busy flag and elapsed
  // busy cycles, plus plain event tallies for the perf counters.
  int m_flush_left   = 0;
  bit m_div_active   = 0;
  int m_div_elapsed  = 0;
  int m_stalls       = 0;
  int m_flushes      = 0;

  task automatic model_cycle(output exp_t e);
    bit hz;
    e = '0;
    if (!rst_n) begin
      m_flush_left  = 0;
      m_div_active  = 0;
      m_div_elapsed = 0;
      m_stalls      = 0;
      m_flushes     = 0;
      return;
    end
    e.stall_cnt = CPU_WIDTH'(m_stalls);
    e.flush_cnt = CPU_WIDTH'(m_flushes);
    hz = ex_load && ex_wr_en && (ex_rd != 0) &&
         ((rd1_en && rs1 == ex_rd) || (rd2_en && rs2 == ex_rd));
    if (m_div_active) begin
      m_div_elapsed++;
      if (div_done) begin
        m_div_active = 0;
      end else if (m_div_elapsed == DTO) begin
        e.div_timeout = 1;
        m_div_active  = 0;
      end else begin
        e.hold_pc = 1; e.hold_if_id = 1; e.hold_id_ex = 1;
      end
    end else if (m_flush_left > 0) begin
      e.flush_if_id = 1;
      m_flush_left--;
    end else if (ex_jump) begin
      e.jump_en = 1; e.jump_adder = jump_tgt;
      e.flush_if_id = 1; e.flush_id_ex = 1;
      m_flush_left = JFC - 1;
    end else begin
      if (hz) begin
        e.hold_pc = 1; e.hold_if_id = 1; e.flush_id_ex = 1;
      end
      if (div_start) begin
        m_div_active  = 1;
        m_div_elapsed = 0;
      end
    end
    if (e.hold_pc)     m_stalls++;
    if (e.flush_if_id) m_flushes++;
  endtask

  task automatic step();
    exp_t e;
    model_cycle(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd1_en = 0; rd2_en = 0; rs1 = '0; rs2 = '0;
    ex_load = 0; ex_wr_en = 0; ex_rd = '0;
    ex_jump = 0; jump_tgt = '0; div_start = 0; div_done = 0;
  endtask

  task automatic idle_steps(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [CPU_WIDTH-1:0] act,
                     input logic [CPU_WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, req);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hold_pc",     hold_pc,     e.hold_pc);
      chk("hold_if_id",  hold_if_id,  e.hold_if_id);
      chk("hold_id_ex",  hold_id_ex,  e.hold_id_ex);
      chk("flush_if_id", flush_if_id, e.flush_if_id);
      chk("flush_id_ex", flush_id_ex, e.flush_id_ex);
      chk("jump_en",     jump_en,     e.jump_en);
      chk("jump_adder",  jump_adder,  e.jump_adder);
      chk("div_timeout", div_timeout, e.div_timeout);
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt",   stall_cnt,   e.stall_cnt);
      chk("flush_cnt",   flush_cnt,   e.flush_cnt);
`endif
    end
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;

    // Reset with active-looking inputs: every output must stay low.
    ex_jump = 1; jump_tgt = 32'hdead_beef; div_start = 1;
    ex_load = 1; ex_wr_en = 1; ex_rd = 5'd3; rd1_en = 1; rs1 = 5'd3;
    step(); step();
    idle_inputs();
    rst_n = 1;
    step();

    // Load-use on rs1, then on rs2, then the same with rd = x0.
    ex_load = 1; ex_wr_en = 1; ex_rd = 5'd5; rd1_en = 1; rs1 = 5'd5;
    step();
    idle_steps(1);
    ex_load = 1; ex_wr_en = 1; ex_rd = 5'd9; rd2_en = 1; rs2 = 5'd9;
    step();
    idle_steps(1);
    ex_load = 1; ex_wr_en = 1; ex_rd = 5'd0; rd1_en = 1; rs1 = 5'd0;
    step();
    idle_steps(1);

    // Jump to 0x100.
    ex_jump = 1; jump_tgt = 32'h0000_0100;
    step();
    idle_steps(3);

    // Divide finishing after 10 cycles, then one load-use stall.
    div_start = 1;
    step();
    idle_steps(9);
    div_done = 1;
    step();
    idle_steps(2);
    ex_load = 1; ex_wr_en = 1; ex_rd = 5'd7; rd1_en = 1; rs1 = 5'd7;
    step();
    idle_steps(1);

    // Divide with no done: watchdog fires once.
    div_start = 1;
    step();
    idle_steps(DTO + 6);

    // Jump + load-use + divide start together: jump only.
    ex_jump = 1; jump_tgt = 32'h0000_2000; div_start = 1;
    ex_load = 1; ex_wr_en = 1; ex_rd = 5'd4; rd2_en = 1; rs2 = 5'd4;
    step();
    idle_steps(4);

    // Reset asserted mid-divide.
    div_start = 1;
    step();
    idle_steps(5);
    rst_n = 0;
    step();
    rst_n = 1;
    idle_steps(3);

    // Randomized traffic over a small register window to provoke matches.
    for (int i = 0; i < 2500; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      rd1_en    = $urandom_range(0, 1);
      rd2_en    = $urandom_range(0, 1);
      rs1       = REG_ADDR_WIDTH'($urandom_range(0, 3));
      rs2       = REG_ADDR_WIDTH'($urandom_range(0, 3));
      ex_load   = $urandom_range(0, 1);
      ex_wr_en  = ($urandom_range(0, 3) != 0);
      ex_rd     = REG_ADDR_WIDTH'($urandom_range(0, 3));
      ex_jump   = ($urandom_range(0, 7) == 0);
      jump_tgt  = $urandom;
      div_start = ($urandom_range(0, 9) == 0);
      div_done  = ($urandom_range(0, 11) == 0);
      step();
    end
    idle_steps(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
